combat_resolver: RTL and testbench

COMBAT_RESOLVER -- requirements
Module: combat_resolver

---
 rtl/combat_resolver.sv | 230 +++++++++++++++++++++++
 tb/tb_combat_resolver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/combat_resolver.sv
// combat_resolver: per-frame hit resolution between two fighters.
// Each player's attack box is tested against the other's hurtbox on every
// SCEN tick. Contacts apply damage, hitstun, invulnerability and knockback,
// and the first player whose health reaches zero ends the match (ko).
// All state advances on the rising clk edge only when SCEN is high.
// Reset is synchronous, active low, and overrides SCEN.
module combat_resolver #(
  parameter int POS_WIDTH      = 10,
  parameter int HP_WIDTH       = 8,
  parameter int HP_MAX         = 100,
  parameter int DMG_LIGHT      = 5,
  parameter int DMG_HEAVY      = 12,
  parameter int DMG_CHIP       = 1,
  parameter int HITSTUN_FRAMES = 12,
  parameter int INVULN_FRAMES  = 20,
  parameter int KB_X_LIGHT     = 4,
  parameter int KB_X_HEAVY     = 8,
  parameter int KB_Y           = -2,
  parameter int HURT_W         = 40,
  parameter int HURT_H         = 45,
  parameter int HURT_OFFX      = 40,
  parameter int HURT_OFFY      = 52,
  parameter int ATK_H          = 80,
  parameter int ATK_FWD        = 85,
  parameter int ATK_UP         = -5,
  parameter int ATK_W_LIGHT    = 40,
  parameter int ATK_W_HEAVY    = 60
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  SCEN,
  input  logic [POS_WIDTH-1:0]  p1_x,
  input  logic [POS_WIDTH-1:0]  p1_y,
  input  logic [POS_WIDTH-1:0]  p2_x,
  input  logic [POS_WIDTH-1:0]  p2_y,
  input  logic                  p1_face_right,
  input  logic                  p1_atk_active,
  input  logic                  p1_atk_heavy,
  input  logic                  p1_block,
  input  logic                  p2_face_right,
  input  logic                  p2_atk_active,
  input  logic                  p2_atk_heavy,
  input  logic                  p2_block,
  output logic                  p1_hit_event,
  output logic                  p1_block_event,
  output logic                  p2_hit_event,
  output logic                  p2_block_event,
  output logic                  p1_hitstun,
  output logic                  p2_hitstun,
  output logic signed [7:0]     p1_kb_dx,
  output logic signed [7:0]     p1_kb_dy,
  output logic signed [7:0]     p2_kb_dx,
  output logic signed [7:0]     p2_kb_dy,
  output logic [HP_WIDTH-1:0]   p1_hp,
  output logic [HP_WIDTH-1:0]   p2_hp,
  output logic                  ko,
  output logic                  p1_win,
  output logic                  p2_win,
  output logic                  draw
);

  // Two extra bits: one for sign, one for headroom so box edges never wrap.
  localparam int BW   = POS_WIDTH + 2;
  localparam int HS_W = $clog2(HITSTUN_FRAMES + 1);
  localparam int IV_W = $clog2(INVULN_FRAMES + 1);

  typedef logic signed [BW-1:0] coord_t;
  typedef logic [HP_WIDTH-1:0]  hp_t;

  // Index 0 is player 1, index 1 is player 2 throughout.
  logic [POS_WIDTH-1:0] pos_x [2];
  logic [POS_WIDTH-1:0] pos_y [2];
  logic                 face  [2];
  logic                 act   [2];
  logic                 heavy [2];
  logic                 guard [2];

  // Box geometry per player.
  coord_t hurt_x0 [2];
  coord_t hurt_y0 [2];
  coord_t atk_x0  [2];
  coord_t atk_y0  [2];
  coord_t atk_w   [2];

  // contact/blocked are indexed by attacker; everything below by defender.
  logic             contact [2];
  logic             blocked [2];
  hp_t              dmg     [2];
  hp_t              nxt_hp  [2];
  logic [7:0]       kb_mag  [2];
  logic signed [7:0] new_kbx [2];
  logic signed [7:0] new_kby [2];

  // Registered state.
  hp_t               hp_q    [2];
  logic [HS_W-1:0]   hs_cnt  [2];
  logic [IV_W-1:0]   inv_cnt [2];
  logic              conn    [2];  // attacker already landed this activation
  logic              hit_q   [2];
  logic              blk_q   [2];
  logic signed [7:0] kbx_q   [2];
  logic signed [7:0] kby_q   [2];

  // Strict interval overlap on one axis; touching edges do not overlap.
  function automatic logic overlap(input coord_t a0, input coord_t aw,
                                   input coord_t b0, input coord_t bw);
    return (a0 < b0 + bw) && (b0 < a0 + aw);
  endfunction

  // Gather per-player inputs into arrays so both directions share one path.
  always_comb begin
    pos_x[0] = p1_x;          pos_x[1] = p2_x;
    pos_y[0] = p1_y;          pos_y[1] = p2_y;
    face[0]  = p1_face_right; face[1]  = p2_face_right;
    act[0]   = p1_atk_active; act[1]   = p2_atk_active;
    heavy[0] = p1_atk_heavy;  heavy[1] = p2_atk_heavy;
    guard[0] = p1_block;      guard[1] = p2_block;
  end

  // Hurtbox and attack box origins in signed, non-wrapping coordinates.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hurt_x0[i] = coord_t'({2'b00, pos_x[i]}) + coord_t'(HURT_OFFX);
      hurt_y0[i] = coord_t'({2'b00, pos_y[i]}) + coord_t'(HURT_OFFY);
      atk_w[i]   = heavy[i] ? coord_t'(ATK_W_HEAVY) : coord_t'(ATK_W_LIGHT);
      atk_y0[i]  = coord_t'({2'b00, pos_y[i]}) + coord_t'(ATK_UP);
      if (face[i]) begin
        atk_x0[i] = coord_t'({2'b00, pos_x[i]}) + coord_t'(ATK_FWD);
      end else begin
        atk_x0[i] = coord_t'({2'b00, pos_x[i]}) + coord_t'(ATK_FWD) - atk_w[i];
      end
    end
  end

  // Contact qualification for attacker i striking defender 1-i.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      contact[i] = act[i] && !conn[i] && (inv_cnt[1-i] == '0) && !ko &&
                   overlap(atk_x0[i], atk_w[i], hurt_x0[1-i], coord_t'(HURT_W)) &&
                   overlap(atk_y0[i], coord_t'(ATK_H), hurt_y0[1-i], coord_t'(HURT_H));
      // Guard only works when the defender faces the attacker.
      blocked[i] = guard[1-i] && (face[1-i] != face[i]);
    end
  end

  // Damage, saturating health and knockback for defender d (attacker 1-d).
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      dmg[d]    = '0;
      kb_mag[d] = heavy[1-d] ? 8'(KB_X_HEAVY) : 8'(KB_X_LIGHT);
      if (contact[1-d]) begin
        if (blocked[1-d]) begin
          dmg[d] = hp_t'(DMG_CHIP);
        end else if (heavy[1-d]) begin
          dmg[d] = hp_t'(DMG_HEAVY);
        end else begin
          dmg[d] = hp_t'(DMG_LIGHT);
        end
      end
      if (blocked[1-d]) begin
        kb_mag[d] = kb_mag[d] >> 1;
      end
      nxt_hp[d]  = (hp_q[d] > dmg[d]) ? (hp_q[d] - dmg[d]) : '0;
      // Push away in the direction the attacker faces.
      new_kbx[d] = face[1-d] ? kb_mag[d] : (8'd0 - kb_mag[d]);
      new_kby[d] = blocked[1-d] ? 8'sd0 : 8'(KB_Y);
    end
  end

  // Per-tick state update: health, counters, event pulses, knockback, ko.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int d = 0; d < 2; d++) begin
        hp_q[d]    <= hp_t'(HP_MAX);
        hs_cnt[d]  <= '0;
        inv_cnt[d] <= '0;
        conn[d]    <= 1'b0;
        hit_q[d]   <= 1'b0;
        blk_q[d]   <= 1'b0;
        kbx_q[d]   <= '0;
        kby_q[d]   <= '0;
      end
      ko     <= 1'b0;
      p1_win <= 1'b0;
      p2_win <= 1'b0;
      draw   <= 1'b0;
    end else if (SCEN) begin
      for (int d = 0; d < 2; d++) begin
        // conn is per attacker: latch on a landed hit, drop when the attack ends.
        conn[d]  <= act[d] && (conn[d] || contact[d]);
        hp_q[d]  <= nxt_hp[d];
        hit_q[d] <= contact[1-d] && !blocked[1-d];
        blk_q[d] <= contact[1-d] && blocked[1-d];
        if (contact[1-d]) begin
          inv_cnt[d] <= IV_W'(INVULN_FRAMES);
          kbx_q[d]   <= new_kbx[d];
          kby_q[d]   <= new_kby[d];
        end else if (inv_cnt[d] != '0) begin
          inv_cnt[d] <= inv_cnt[d] - IV_W'(1);
        end
        if (contact[1-d] && !blocked[1-d]) begin
          hs_cnt[d] <= HS_W'(HITSTUN_FRAMES);
        end else if (hs_cnt[d] != '0) begin
          hs_cnt[d] <= hs_cnt[d] - HS_W'(1);
        end
      end
      // ko latches on the tick health first reaches zero and holds to reset.
      if (!ko && ((nxt_hp[0] == '0) || (nxt_hp[1] == '0))) begin
        ko     <= 1'b1;
        p1_win <= (nxt_hp[1] == '0) && (nxt_hp[0] != '0);
        p2_win <= (nxt_hp[0] == '0) && (nxt_hp[1] != '0);
        draw   <= (nxt_hp[0] == '0) && (nxt_hp[1] == '0);
      end
    end
  end

  assign p1_hp          = hp_q[0];
  assign p2_hp          = hp_q[1];
  assign p1_hitstun     = (hs_cnt[0] != '0);
  assign p2_hitstun     = (hs_cnt[1] != '0);
  assign p1_hit_event   = hit_q[0];
  assign p2_hit_event   = hit_q[1];
  assign p1_block_event = blk_q[0];
  assign p2_block_event = blk_q[1];
  assign p1_kb_dx       = kbx_q[0];
  assign p1_kb_dy       = kby_q[0];
  assign p2_kb_dx       = kbx_q[1];
  assign p2_kb_dy       = kby_q[1];

endmodule

// File: tb/tb_combat_resolver.sv
// tb_combat_resolver: directed scenarios for combat_resolver.
// Each tick the expected output snapshot is pushed to exp_q, the clock
// advances, and the DUT snapshot is compared against the popped entry.
module tb_combat_resolver;

  localparam int W = 58;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic SCEN = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic p1_face_right, p1_atk_active, p1_atk_heavy, p1_block;
  logic p2_face_right, p2_atk_active, p2_atk_heavy, p2_block;
  logic p1_hit_event, p1_block_event, p2_hit_event, p2_block_event;
  logic p1_hitstun, p2_hitstun;
  logic signed [7:0] p1_kb_dx, p1_kb_dy, p2_kb_dx, p2_kb_dy;
  logic [7:0] p1_hp, p2_hp;
  logic ko, p1_win, p2_win, draw;

  combat_resolver dut (
    .clk(clk), .reset_n(reset_n), .SCEN(SCEN),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_face_right(p1_face_right), .p1_atk_active(p1_atk_active),
    .p1_atk_heavy(p1_atk_heavy), .p1_block(p1_block),
    .p2_face_right(p2_face_right), .p2_atk_active(p2_atk_active),
    .p2_atk_heavy(p2_atk_heavy), .p2_block(p2_block),
    .p1_hit_event(p1_hit_event), .p1_block_event(p1_block_event),
    .p2_hit_event(p2_hit_event), .p2_block_event(p2_block_event),
    .p1_hitstun(p1_hitstun), .p2_hitstun(p2_hitstun),
    .p1_kb_dx(p1_kb_dx), .p1_kb_dy(p1_kb_dy),
    .p2_kb_dx(p2_kb_dx), .p2_kb_dy(p2_kb_dy),
    .p1_hp(p1_hp), .p2_hp(p2_hp),
    .ko(ko), .p1_win(p1_win), .p2_win(p2_win), .draw(draw)
  );

  // Scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // Expected output state, index 0 = player 1, 1 = player 2.
  logic       ex_hit [2];
  logic       ex_blk [2];
  int         ex_hs  [2];
  logic [7:0] ex_kbx [2];
  logic [7:0] ex_kby [2];
  logic [7:0] ex_hp  [2];
  logic       ex_ko, ex_p1w, ex_p2w, ex_draw;

  function automatic logic [W-1:0] pack_exp();
    return {ex_hit[0], ex_blk[0], ex_hit[1], ex_blk[1],
            (ex_hs[0] != 0), (ex_hs[1] != 0),
            ex_kbx[0], ex_kby[0], ex_kbx[1], ex_kby[1],
            ex_hp[0], ex_hp[1], ex_ko, ex_p1w, ex_p2w, ex_draw};
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 2; i++) begin
      ex_hit[i] = 1'b0; ex_blk[i] = 1'b0; ex_hs[i] = 0;
      ex_kbx[i] = 8'd0; ex_kby[i] = 8'd0; ex_hp[i] = 8'd100;
    end
    ex_ko = 1'b0; ex_p1w = 1'b0; ex_p2w = 1'b0; ex_draw = 1'b0;
  endtask

  // One SCEN tick with no contact: pulses drop, hitstun decays.
  task automatic adv_model();
    for (int i = 0; i < 2; i++) begin
      ex_hit[i] = 1'b0;
      ex_blk[i] = 1'b0;
      if (ex_hs[i] > 0) ex_hs[i] = ex_hs[i] - 1;
    end
  endtask

  task automatic apply_hit(input int d, input int hp, input int kbx, input int kby,
                           input bit blocked);
    ex_hp[d]  = 8'(hp);
    ex_kbx[d] = 8'(kbx);
    ex_kby[d] = 8'(kby);
    if (blocked) begin
      ex_blk[d] = 1'b1;
    end else begin
      ex_hit[d] = 1'b1;
      ex_hs[d]  = 12;
    end
  endtask

  // Driver + checker: one clock with SCEN=en, then compare snapshot.
  task automatic tick_chk(input string tag, input logic en);
    logic [W-1:0] got;
    logic [W-1:0] want;
    exp_q.push_back(pack_exp());
    SCEN = en;
    @(posedge clk);
    #1;
    got = {p1_hit_event, p1_block_event, p2_hit_event, p2_block_event,
           p1_hitstun, p2_hitstun, p1_kb_dx, p1_kb_dy, p2_kb_dx, p2_kb_dy,
           p1_hp, p2_hp, ko, p1_win, p2_win, draw};
    want = exp_q.pop_front();
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s (check %0d): observed=%h expected=%h", tag, n_tests, got, want);
    end
  endtask

  task automatic step(input string tag);
    adv_model();
    tick_chk(tag, 1'b1);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic do_reset(input string tag, input logic en);
    reset_n = 1'b0;
    p1_x = 10'd100; p1_y = 10'd200; p1_face_right = 1'b1;
    p2_x = 10'd160; p2_y = 10'd200; p2_face_right = 1'b0;
    p1_atk_active = 1'b0; p1_atk_heavy = 1'b0; p1_block = 1'b0;
    p2_atk_active = 1'b0; p2_atk_heavy = 1'b0; p2_block = 1'b0;
    clear_exp();
    tick_chk(tag, en);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset with SCEN low, then idle.
    do_reset("reset_scen0", 1'b0);
    idle(2, "idle_after_reset");

    // Light hit in range, then hitstun lasts exactly 12 ticks.
    p1_atk_active = 1'b1;
    adv_model(); apply_hit(1, 95, 4, -2, 0);
    tick_chk("light_hit", 1'b1);
    p1_atk_active = 1'b0;
    idle(13, "hitstun_decay");

    // Out of range, edge touching, and one pixel inside.
    do_reset("reset_range", 1'b1);
    p2_x = 10'd300; p1_atk_active = 1'b1; step("miss_far");
    p1_atk_active = 1'b0; step("miss_far_release");
    p2_x = 10'd185; p1_atk_active = 1'b1; step("miss_edge_touch");
    p1_atk_active = 1'b0; step("miss_edge_release");
    p2_x = 10'd184; p1_atk_active = 1'b1;
    adv_model(); apply_hit(1, 95, 4, -2, 0);
    tick_chk("hit_edge_inside", 1'b1);
    p1_atk_active = 1'b0;
    idle(2, "edge_after");

    // Heavy held for 30 ticks hits once; re-press hits again.
    do_reset("reset_heavy", 1'b1);
    p1_atk_heavy = 1'b1; p1_atk_active = 1'b1;
    adv_model(); apply_hit(1, 88, 8, -2, 0);
    tick_chk("heavy_hit", 1'b1);
    idle(29, "heavy_held_single");
    p1_atk_active = 1'b0; step("heavy_release");
    p1_atk_active = 1'b1;
    adv_model(); apply_hit(1, 76, 8, -2, 0);
    tick_chk("heavy_rehit", 1'b1);
    p1_atk_active = 1'b0; p1_atk_heavy = 1'b0;
    idle(2, "heavy_after");

    // Guard facing the attacker blocks; guard facing away does not.
    do_reset("reset_block", 1'b1);
    p2_block = 1'b1; p2_face_right = 1'b0; p1_atk_active = 1'b1;
    adv_model(); apply_hit(1, 99, 2, 0, 1);
    tick_chk("blocked_hit", 1'b1);
    p1_atk_active = 1'b0;
    idle(22, "after_block");
    p2_face_right = 1'b1; p1_atk_active = 1'b1;
    adv_model(); apply_hit(1, 94, 4, -2, 0);
    tick_chk("block_facing_away", 1'b1);
    p1_atk_active = 1'b0; p2_block = 1'b0; p2_face_right = 1'b0;
    idle(2, "block_after");

    // Repeated trades down to a double KO.
    do_reset("reset_trade", 1'b1);
    p2_x = 10'd120;
    for (int k = 1; k <= 20; k++) begin
      p1_atk_active = 1'b1; p2_atk_active = 1'b1;
      adv_model();
      apply_hit(0, 100 - 5 * k, -4, -2, 0);
      apply_hit(1, 100 - 5 * k, 4, -2, 0);
      if (k == 20) begin
        ex_ko = 1'b1; ex_draw = 1'b1;
      end
      tick_chk("trade", 1'b1);
      p1_atk_active = 1'b0; p2_atk_active = 1'b0;
      idle(22, "trade_gap");
    end
    p1_atk_active = 1'b1; p2_atk_active = 1'b1;
    step("after_ko_ignored");
    p1_atk_active = 1'b0; p2_atk_active = 1'b0;
    step("after_ko_idle");

    // Heavy series saturates health at 0 and gives player 1 the win.
    do_reset("reset_sat", 1'b1);
    p1_atk_heavy = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      p1_atk_active = 1'b1;
      adv_model();
      apply_hit(1, (k < 9) ? (100 - 12 * k) : 0, 8, -2, 0);
      if (k == 9) begin
        ex_ko = 1'b1; ex_p1w = 1'b1;
      end
      tick_chk("heavy_series", 1'b1);
      p1_atk_active = 1'b0;
      idle(22, "heavy_gap");
    end
    p1_atk_heavy = 1'b0;

    // Reset mid-hitstun with SCEN high.
    do_reset("reset_pre", 1'b1);
    p1_atk_active = 1'b1;
    adv_model(); apply_hit(1, 95, 4, -2, 0);
    tick_chk("hit_before_reset", 1'b1);
    p1_atk_active = 1'b0;
    idle(4, "hitstun_pre_reset");
    do_reset("reset_mid_hitstun", 1'b1);

    // SCEN gaps: state holds, hitstun counted in SCEN ticks only.
    p1_atk_active = 1'b1;
    adv_model(); apply_hit(1, 95, 4, -2, 0);
    tick_chk("gap_hit", 1'b1);
    p1_atk_active = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick_chk("gap_hold", 1'b0);
      step("gap_tick");
    end
    step("gap_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
